// File: rtl/wb_cmd_initiator_pkg.sv
// Shared types and defaults for the Wishbone command initiator.
// Holds FSM state encoding, bus width defaults and the error read value.
package wb_cmd_initiator_pkg;

    localparam int DEF_ADDRWIDTH = 17;
    localparam int DEF_DATAWIDTH = 32;

    // Returned on reads that never see an ACK; also used by the aggregation block
    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_ack_timeout.sv
// ACK-wait counter: clears, counts enabled cycles, flags the final cycle.
// Ports: clk, rst (async high), clear, enable, expire (count == LIMIT-1).
module wb_ack_timeout #(
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    // expire marks the last permitted wait cycle, so the owner aborts
    // on the edge that closes cycle number TIMEOUT_CYCLES
    assign expire = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone initiator: one single-word bus cycle per valid/ready command,
// one response per command, with an ACK timeout so a hung responder
// cannot stall it.
// Ports: WBs_CLK_i/WBs_RST_i clock and async high reset;
//   cmd_* command channel (valid/ready, we, adr, be, dat);
//   rsp_* response channel (valid/ready, dat, err);
//   WBs_* Wishbone bus signals; busy_o high whenever not idle.
module wb_cmd_initiator
    import wb_cmd_initiator_pkg::*;
#(
    parameter int ADDRWIDTH      = DEF_ADDRWIDTH,
    parameter int DATAWIDTH      = DEF_DATAWIDTH,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATAWIDTH-1:0] ERR_READ_VALUE = DEFAULT_READ_VALUE
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [ADDRWIDTH-1:0]   cmd_adr_i,
    input  logic [DATAWIDTH/8-1:0] cmd_be_i,
    input  logic [DATAWIDTH-1:0]   cmd_dat_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATAWIDTH-1:0]   rsp_dat_o,
    output logic                   rsp_err_o,
    output logic [ADDRWIDTH-1:0]   WBs_ADR_o,
    output logic                   WBs_CYC_o,
    output logic                   WBs_STB_o,
    output logic                   WBs_WE_o,
    output logic                   WBs_RD_o,
    output logic [DATAWIDTH/8-1:0] WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]   WBs_WR_DAT_o,
    input  logic [DATAWIDTH-1:0]   WBs_RD_DAT_i,
    input  logic                   WBs_ACK_i,
    output logic                   busy_o
);

    wb_state_t state;
    logic      tmo_clear;
    logic      tmo_enable;
    logic      tmo_expire;

    // Counter sits at zero outside BUS, so it is clear on entry
    assign tmo_clear  = (state != ST_BUS);
    assign tmo_enable = (state == ST_BUS) && !WBs_ACK_i;

    wb_ack_timeout #(
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (WBs_CLK_i),
        .rst    (WBs_RST_i),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state          <= ST_IDLE;
            cmd_ready_o    <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_dat_o      <= '0;
            rsp_err_o      <= 1'b0;
            WBs_ADR_o      <= '0;
            WBs_CYC_o      <= 1'b0;
            WBs_STB_o      <= 1'b0;
            WBs_WE_o       <= 1'b0;
            WBs_RD_o       <= 1'b0;
            WBs_BYTE_STB_o <= '0;
            WBs_WR_DAT_o   <= '0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_ready_o && cmd_valid_i) begin
                        state          <= ST_BUS;
                        cmd_ready_o    <= 1'b0;
                        busy_o         <= 1'b1;
                        WBs_CYC_o      <= 1'b1;
                        WBs_STB_o      <= 1'b1;
                        WBs_WE_o       <= cmd_we_i;
                        WBs_RD_o       <= ~cmd_we_i;
                        WBs_ADR_o      <= {cmd_adr_i[ADDRWIDTH-1:2], 2'b00};
                        WBs_BYTE_STB_o <= cmd_be_i;
                        WBs_WR_DAT_o   <= cmd_dat_i;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // ACK is tested first so a late ACK beats the timeout
                    if (WBs_ACK_i) begin
                        state       <= ST_RESP;
                        WBs_CYC_o   <= 1'b0;
                        WBs_STB_o   <= 1'b0;
                        WBs_WE_o    <= 1'b0;
                        WBs_RD_o    <= 1'b0;
                        rsp_dat_o   <= WBs_WE_o ? '0 : WBs_RD_DAT_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                    end else if (tmo_expire) begin
                        state       <= ST_RESP;
                        WBs_CYC_o   <= 1'b0;
                        WBs_STB_o   <= 1'b0;
                        WBs_WE_o    <= 1'b0;
                        WBs_RD_o    <= 1'b0;
                        rsp_dat_o   <= ERR_READ_VALUE;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone initiator (master) for the FPGA fabric bus that the IP aggregation responders sit on.
- Takes single-word read/write commands on a valid/ready port, runs one Wishbone cycle per command, and returns one response per command.
- Includes an ACK timeout: an unmapped or hung responder cannot stall it.
- Used for on-fabric bring-up, self-test and DMA-style register sequencing against the timer controller and reserved-register blocks.

Parameters:
- ADDRWIDTH, 17, byte-address width (aperture width).
- DATAWIDTH, 32, data bus width; byte strobes = DATAWIDTH/8.
- TIMEOUT_WIDTH, 8, width of the ACK-wait counter.
- TIMEOUT_CYCLES, 255, CYC-high cycles without ACK before abort; legal range 1..2^TIMEOUT_WIDTH-1.
- ERR_READ_VALUE, 32'hBAD_FAB_AC, rsp_dat_o value on timeout.

Ports:
- WBs_CLK_i in 1: clock.
- WBs_RST_i in 1: reset; asynchronous, active-high.
- cmd_valid_i in 1: command present.
- cmd_ready_o out 1: command accepted when valid&ready at the clock edge.
- cmd_we_i in 1: 1 = write, 0 = read.
- cmd_adr_i in ADDRWIDTH: byte address.
- cmd_be_i in 4: byte enables.
- cmd_dat_i in DATAWIDTH: write data.
- rsp_valid_o out 1: response present.
- rsp_ready_i in 1: response consumed when valid&ready at the clock edge.
- rsp_dat_o out DATAWIDTH: read data, 0 for writes, or ERR_READ_VALUE on timeout.
- rsp_err_o out 1: timeout occurred.
- WBs_ADR_o out ADDRWIDTH: bus address; bits [1:0] always 0.
- WBs_CYC_o out 1: cycle.
- WBs_STB_o out 1: strobe.
- WBs_WE_o out 1: write enable.
- WBs_RD_o out 1: read enable.
- WBs_BYTE_STB_o out 4: byte strobes.
- WBs_WR_DAT_o out DATAWIDTH: write data.
- WBs_RD_DAT_i in DATAWIDTH: read data from the responder mux.
- WBs_ACK_i in 1: combined ACK from responders.
- busy_o out 1: FSM not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (async assert) drives every output to 0 and the FSM to IDLE; cmd_ready_o goes 1 on the first edge after reset deasserts.
- FSM states and transitions:
  - IDLE: cmd_ready_o = 1. On accept, latch cmd fields and go to BUS. On that same edge CYC/STB go 1 and WE/ADR/BYTE_STB/WR_DAT are driven. WBs_ADR_o = {cmd_adr_i[ADDRWIDTH-1:2], 2'b00}.
  - BUS: cmd_ready_o = 0; WBs_RD_o = ~WE while CYC is high.
    - Timeout counter clears on entry and increments each cycle ACK is low.
    - ACK high at an edge: CYC/STB/WE/RD drop to 0 on that edge; rsp_dat_o = WBs_RD_DAT_i for reads, 0 for writes; rsp_err_o = 0; rsp_valid_o = 1; go to RESP.
    - Counter reaches TIMEOUT_CYCLES with ACK low: drop the bus; rsp_dat_o = ERR_READ_VALUE, rsp_err_o = 1, rsp_valid_o = 1; go to RESP.
    - ACK and timeout on the same edge: ACK wins (normal response).
  - RESP: rsp_* held stable until rsp_valid_o & rsp_ready_i; then rsp_valid_o = 0, go to IDLE. cmd_ready_o stays 0 in RESP; no overlap of commands.
- Latency: with a zero-wait responder (ACK in the first CYC cycle), accept at edge N → CYC high N..N+1 → rsp_valid_o high after N+1. Each responder wait state adds 1 cycle.
- CYC and STB are always asserted and deasserted together; one beat per cycle, no bursts.
- WBs_ADR_o, WBs_BYTE_STB_o and WBs_WR_DAT_o are held constant for the whole cycle.
- cmd_be_i = 0000 still issues a cycle.
- WBs_ACK_i outside BUS is ignored.
- WBs_RST_i asserted mid-cycle: CYC/STB drop asynchronously; the pending response is discarded.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/BUS/RESP);
  - ERR_READ_VALUE / DEFAULT_READ_VALUE constant (shared with the aggregation block);
  - ADDRWIDTH/DATAWIDTH defaults.
- One natural sub-module: wb_ack_timeout. Counter with clear/enable/expire, parameterised by TIMEOUT_WIDTH/TIMEOUT_CYCLES, reusable by other initiators.

Test Plan:
- Write 0x0000_00A5 to 0x04004 with BE=1111, ACK in the first CYC cycle → ADR=0x04004, WE=1, RD=0, CYC high exactly 1 cycle; rsp_valid_o after 2 edges; rsp_dat_o = 0, rsp_err_o = 0.
- Read 0x051FC with responder returning 0x0001_0000 after 3 wait states → CYC high 4 cycles, RD=1, WE=0; rsp_dat_o = 0x0001_0000, rsp_err_o = 0.
- Read 0x1F000 with no ACK, TIMEOUT_CYCLES=255 → CYC drops after 255 cycles; rsp_dat_o = 0xBADFABAC, rsp_err_o = 1.
- TIMEOUT_CYCLES=4, ACK arrives exactly on the 4th cycle → normal response with the bus data, rsp_err_o = 0.
- rsp_ready_i held low 10 cycles with cmd_valid_i high → rsp_* stable; cmd_ready_o = 0; no new CYC until the response handshake, then the next command is accepted.
- cmd_adr_i = 0x04007 → WBs_ADR_o = 0x04004. Separately, assert WBs_RST_i 2 cycles into a 5-wait read → CYC/STB = 0 immediately, rsp_valid_o = 0, busy_o = 0.
